// File: rtl/mgemm_acc_pkg.sv
// Shared types and default widths for the GEMV
// carry-save dot-product accumulator.
package mgemm_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    OUTPUT
  } state_e;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/csa_3to2_eq.sv
// Equal-width 3:2 carry-save compressor.
// Carry is pre-shifted left; the top carry is dropped.
module csa_3to2_eq #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/csa_dot_accumulator.sv
// Redundant-form dot-product accumulator: CSA per beat,
// one carry-propagate add when the last term arrives.
module csa_dot_accumulator
  import mgemm_acc_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
);

  state_e     state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] csa_s;
  logic [ACC_W-1:0] csa_c;
  logic             accept;

  assign term = ACC_W'(in_data);

  csa_3to2_eq #(
    .W (ACC_W)
  ) u_csa (
    .a     (term),
    .b     (s_q),
    .c     (c_q),
    .sum   (csa_s),
    .carry (csa_c)
  );

  // Handshake outputs are pure state decodes.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUTPUT);
  assign out_data  = res_q;
  assign out_cnt   = rcnt_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          s_d   = csa_s;
          c_d   = csa_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        res_d   = s_q + c_q;
        rcnt_d  = cnt_q;
        s_d     = '0;
        c_d     = '0;
        cnt_d   = '0;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_csa_dot_accumulator.sv
// Bench for csa_dot_accumulator: directed scenarios plus
// random dot products against a plain-arithmetic sum model.
module tb_csa_dot_accumulator;

  localparam int IN_W  = 16;
  localparam int ACC_W = 24;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  csa_dot_accumulator #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one term and holds it until accepted.
  task automatic send_beat(input logic [IN_W-1:0] d,
                           input logic last);
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    if (g >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int g = 0;
    while (!out_valid && g < 50) begin
      tick();
      g++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: v=%0b d=%h c=%0d want 0/0/0",
               out_valid, out_data, out_cnt);
    end
    #21;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: rdy=%0b v=%0b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    send_beat(16'd3, 1'b0);
    send_beat(16'd5, 1'b0);
    send_beat(16'd7, 1'b0);
    send_beat(16'd9, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_resolve: v=%0b rdy=%0b want 0/0",
               out_valid, in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 24'd24 || out_cnt !== 8'd4) begin
      n_bad++;
      $display("FAIL basic_result: v=%0b d=%0d c=%0d want 1/24/4",
               out_valid, out_data, out_cnt);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_return: rdy=%0b v=%0b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    bit ok;
    send_beat(16'hABCD, 1'b1);
    wait_out(ok);
    n_cmp++;
    if (!ok || out_data !== 24'h00ABCD || out_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL single: v=%0b d=%h c=%0d want 1/00abcd/1",
               out_valid, out_data, out_cnt);
    end
    tick();
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < 300; i++)
      send_beat(16'hFFFF, i == 299);
    wait_out(ok);
    n_cmp++;
    if (!ok || out_data !== 24'h2BFED4 || out_cnt !== 8'd44) begin
      n_bad++;
      $display("FAIL wrap: v=%0b d=%h c=%0d want 1/2bfed4/44",
               out_valid, out_data, out_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    send_beat(16'd10, 1'b0);
    send_beat(16'd20, 1'b1);
    wait_out(ok);
    // Terms offered while the block is busy must be ignored.
    in_valid = 1'b1;
    in_data  = 16'h7777;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (!ok || out_valid !== 1'b1 || out_data !== 24'd30 ||
          out_cnt !== 8'd2 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: v=%0b d=%0d c=%0d rdy=%0b want 1/30/2/0",
                 i, out_valid, out_data, out_cnt, in_ready);
      end
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: v=%0b rdy=%0b want 0/1",
               out_valid, in_ready);
    end
    send_beat(16'd1, 1'b0);
    send_beat(16'd1, 1'b1);
    wait_out(ok);
    n_cmp++;
    if (!ok || out_data !== 24'd2 || out_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL bp_next: d=%0d c=%0d want 2/2", out_data, out_cnt);
    end
    tick();
  endtask

  task automatic test_bubbles();
    bit ok;
    int acc = 0;
    int g   = 0;
    while (acc < 10 && g < 500) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'd100;
      in_last  = (acc == 9) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!in_valid) in_last = 1'($urandom_range(0, 1));
      else if (acc != 9) in_last = 1'b0;
      if (in_valid && in_ready) acc++;
      tick();
      g++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out(ok);
    n_cmp++;
    if (!ok || out_data !== 24'd1000 || out_cnt !== 8'd10) begin
      n_bad++;
      $display("FAIL bubbles: v=%0b d=%0d c=%0d want 1/1000/10",
               out_valid, out_data, out_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    bit ok;
    for (int k = 0; k < 8; k++) begin
      int n = $urandom_range(1, 40);
      longint unsigned total = 0;
      for (int i = 0; i < n; i++) begin
        logic [IN_W-1:0] v = IN_W'($urandom);
        if ($urandom_range(0, 3) == 0) tick();
        send_beat(v, i == n - 1);
        total += longint'(v);
      end
      total = total % (64'd1 << ACC_W);
      wait_out(ok);
      n_cmp++;
      if (!ok || out_data !== ACC_W'(total) || out_cnt !== CNT_W'(n)) begin
        n_bad++;
        $display("FAIL random[%0d]: d=%h c=%0d want %h/%0d",
                 k, out_data, out_cnt, ACC_W'(total), CNT_W'(n));
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    send_beat(16'd11, 1'b0);
    send_beat(16'd22, 1'b0);
    send_beat(16'd33, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 ||
        out_cnt !== '0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_mid: v=%0b d=%h c=%0d rdy=%0b want 0/0/0/1",
               out_valid, out_data, out_cnt, in_ready);
    end
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    send_beat(16'd2, 1'b0);
    send_beat(16'd4, 1'b1);
    wait_out(ok);
    n_cmp++;
    if (!ok || out_data !== 24'd6 || out_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL arst_resume: d=%0d c=%0d want 6/2",
               out_data, out_cnt);
    end
    out_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0) begin
      n_bad++;
      $display("FAIL arst_output: v=%0b d=%h c=%0d want 0/0/0",
               out_valid, out_data, out_cnt);
    end
    #4;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_wrap();
    test_backpressure();
    test_bubbles();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csa_dot_accumulator.md
# csa_dot_accumulator

Sequential reduction stage directly downstream of the 3:2 carry-save compressors in the GEMV datapath. It accepts one compressed partial-product term per handshake beat and folds it into a redundant (sum, carry) accumulator pair through a 3:2 CSA, so no carry propagates per beat. On the beat flagged `in_last` it resolves the pair with a single carry-propagate add and presents the finished dot-product result to the output/writeback stage.

## Interface
- `IN_W`, default 16: width of each incoming term (unsigned).
- `ACC_W`, default 24: accumulator and result width; must satisfy ACC_W ≥ IN_W.
- `CNT_W`, default 8: width of the beat counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  upstream term valid.
- `in_ready`  out  1  block can accept a term.
- `in_data`  in  IN_W  term, zero-extended to ACC_W.
- `in_last`  in  1  term is the final one of the current dot product.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  ACC_W  resolved sum, modulo 2^ACC_W.
- `out_cnt`  out  CNT_W  number of beats in this dot product, modulo 2^CNT_W.

## Operation
- States: ACCUM (default), RESOLVE, OUTPUT.
- ACCUM:
  - `in_ready`=1.
  - On accept (`in_valid`&&`in_ready`): S←CSA_sum(in_data, S, C) and C←CSA_carry(...)<<1, truncated to ACC_W. The carry out of bit ACC_W-1 is discarded, which is exact modulo 2^ACC_W.
  - cnt←cnt+1 (wraps).
  - If `in_last`=1 on the accepted beat, go to RESOLVE.
- RESOLVE (one cycle):
  - `in_ready`=0.
  - out_data←S+C (ACC_W-bit add, carry dropped).
  - out_cnt←cnt.
  - S, C, cnt cleared.
  - Go to OUTPUT.
- OUTPUT:
  - `in_ready`=0, `out_valid`=1.
  - `out_data` and `out_cnt` held stable until `out_ready`=1.
  - When `out_ready`=1, go to ACCUM.
- `in_last` on a non-accepted cycle is ignored.
- A single-beat dot product (first beat has `in_last`=1) is legal and produces out_cnt=1.
- Reset (asynchronous, any state including mid-accumulation or mid-OUTPUT):
  - State→ACCUM.
  - S=C=0, cnt=0.
  - `out_valid`=0, `out_data`=0, `out_cnt`=0.
  - `in_ready` is 1 after reset.
  - Any partial accumulation is discarded.

## Timing
- Throughput: one term per cycle while in ACCUM.
- Latency: `in_last` accepted at edge t → RESOLVE during cycle t+1 → `out_valid`=1 from cycle t+2.
- `in_ready` falls combinationally with state; it is a registered state decode, so there is no combinational path from `out_ready`.
- Minimum gap between the last beat of one dot product and the first beat of the next is 2 cycles when `out_ready` is held high: that beat can be accepted at the earliest in the cycle after the OUTPUT handshake.
- Back-pressure: if `out_ready`=0, the block holds OUTPUT indefinitely with outputs stable; upstream sees `in_ready`=0.
- No valid-drop: `out_valid` never deasserts before the handshake except on reset.

## Structure
- Shared package `mgemm_acc_pkg`:
  - state enum {ACCUM, RESOLVE, OUTPUT};
  - default width constants IN_W/ACC_W/CNT_W.
- Sub-module `csa_3to2_eq`: parameterised equal-width (ACC_W) combinational 3:2 compressor with outputs sum[ACC_W] and carry[ACC_W]. The carry is pre-shifted left by one, bit 0 = 0, and the top carry is dropped.
- The accumulator instantiates it once. The final S+C is a plain adder in the parent, not a separate module.

## Test plan
- Reset then 4 beats 3, 5, 7, 9 (`in_last` on 9), `out_ready`=1 → `out_valid` two cycles after the last accept, out_data=24, out_cnt=4, then `in_ready`=1 the next cycle.
- Single beat 0xABCD with `in_last`=1 → out_data=0x00ABCD, out_cnt=1.
- ACC_W=24, 300 beats of 0xFFFF → out_data=(300·65535) mod 2^24=0x2BFED4; out_cnt=300 mod 256=44.
- `out_ready`=0 for 5 cycles in OUTPUT → `out_valid` and `out_data` stable and `in_ready`=0 throughout; handshake on cycle 6; a following dot product 1, 1 (last) → out_data=2 with no leftover from the previous one.
- Random `in_valid` bubbles during 10 beats of value 100 → out_data=1000, out_cnt=10; beats presented while `in_ready`=0 are not counted.
- Assert `rst_n`=0 asynchronously mid-accumulation (after 3 beats), then resume with 2, 4 (last) → out_data=6, out_cnt=2; all outputs read 0 while in reset.
